// File: rtl/vga_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | vga_pkg: shared defaults, types and FSM encoding for the pixel  |
// | sink path.                         Revision: 1.0                |
// +-----------------------------------------------------------------+
package vga_pkg;

    localparam int H_RES_DEF  = 640;
    localparam int V_RES_DEF  = 480;
    localparam int ADDR_W_DEF = 19;
    localparam int COLR_W_DEF = 4;

    typedef logic [COLR_W_DEF-1:0] colr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } fsm_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        colr_t                 colr;
    } pix_word_t;

endpackage

`default_nettype wire

// File: rtl/pix_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pix_fifo: first-word-fall-through FIFO; dout shows the head     |
// | entry whenever empty is low.       Revision: 1.0                |
// +-----------------------------------------------------------------+
module pix_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign dout  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = din;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fb_pixel_writer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fb_pixel_writer: clips pixel beats, linearises them into        |
// | framebuffer writes, and runs the frame-clear sweep.  Rev: 1.0   |
// +-----------------------------------------------------------------+
module fb_pixel_writer
    import vga_pkg::*;
#(
    parameter int XY_BITW    = 16,
    parameter int H_RES      = H_RES_DEF,
    parameter int V_RES      = V_RES_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int COLR_W     = COLR_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [XY_BITW-1:0] pix_x,
    input  logic [XY_BITW-1:0] pix_y,
    input  logic [COLR_W-1:0]  pix_colr,
    input  logic               pix_valid,
    input  logic               pix_last,
    output logic               pix_ready,
    input  logic               clear_start,
    input  logic [COLR_W-1:0]  clear_colr,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLR_W-1:0]  mem_data,
    output logic               mem_we,
    input  logic               mem_ready,
    output logic               busy,
    output logic               clear_done,
    output logic [15:0]        line_count,
    output logic [15:0]        clip_count
);

    localparam int FIFO_W = ADDR_W + COLR_W;
    localparam int PROD_W = 2 * XY_BITW + 2;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(H_RES * V_RES - 1);

    fsm_e              state_q, state_d;
    logic              clear_pend_q, clear_pend_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [COLR_W-1:0] clr_colr_q, clr_colr_d;
    logic              clear_done_q, clear_done_d;
    logic [15:0]       line_count_q, line_count_d;
    logic [15:0]       clip_count_q, clip_count_d;

    logic              accept, in_range, fifo_push, fifo_pop;
    logic              fifo_full, fifo_empty;
    logic [ADDR_W-1:0] pix_addr;
    logic [FIFO_W-1:0] fifo_dout;

    // Reset gating keeps every output low while rst_n is asserted.
    assign pix_ready = rst_n && (state_q == IDLE) && !fifo_full && !clear_pend_q;
    assign accept    = pix_valid && pix_ready;
    assign in_range  = (int'(pix_x) < H_RES) && (int'(pix_y) < V_RES);
    assign fifo_push = accept && in_range;
    assign pix_addr  = ADDR_W'(PROD_W'(pix_y) * PROD_W'(H_RES) + PROD_W'(pix_x));

    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign clear_done = clear_done_q;
    assign line_count = line_count_q;
    assign clip_count = clip_count_q;

    pix_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   ({pix_addr, pix_colr}),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    always_comb begin
        state_d      = state_q;
        clear_pend_d = clear_pend_q;
        clr_cnt_d    = clr_cnt_q;
        clr_colr_d   = clr_colr_q;
        clear_done_d = 1'b0;
        line_count_d = line_count_q;
        clip_count_d = clip_count_q;
        fifo_pop     = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_data     = '0;

        if (accept && pix_last) begin
            line_count_d = line_count_q + 16'd1;
        end
        if (accept && !in_range && (clip_count_q != 16'hFFFF)) begin
            clip_count_d = clip_count_q + 16'd1;
        end

        // Queued pixels keep draining in IDLE and DRAIN; the sweep owns the port in CLEAR.
        if (state_q == CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = clr_cnt_q;
            mem_data = clr_colr_q;
        end else if (!fifo_empty) begin
            mem_we   = 1'b1;
            mem_addr = fifo_dout[FIFO_W-1:COLR_W];
            mem_data = fifo_dout[COLR_W-1:0];
            fifo_pop = mem_ready;
        end

        case (state_q)
            IDLE: begin
                if (clear_pend_q) begin
                    state_d      = DRAIN;
                    clear_pend_d = 1'b0;
                end else if (clear_start) begin
                    clear_pend_d = 1'b1;
                    clr_colr_d   = clear_colr;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                if (mem_ready) begin
                    if (clr_cnt_q == CLR_LAST) begin
                        state_d      = IDLE;
                        clear_done_d = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            clear_pend_q <= 1'b0;
            clr_cnt_q    <= '0;
            clr_colr_q   <= '0;
            clear_done_q <= 1'b0;
            line_count_q <= '0;
            clip_count_q <= '0;
        end else begin
            state_q      <= state_d;
            clear_pend_q <= clear_pend_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_colr_q   <= clr_colr_d;
            clear_done_q <= clear_done_d;
            line_count_q <= line_count_d;
            clip_count_q <= clip_count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_fb_pixel_writer: exercises a 640x480 and a 4x2 instance      |
// | against a write-list reference model.  Revision: 1.0            |
// +-----------------------------------------------------------------+
module tb_fb_pixel_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [15:0] bx, by, b_lines, b_clips;
    logic [3:0]  bc, b_cc, b_data;
    logic        bv, bl, b_ready, b_cs, b_we, b_mr, b_busy, b_done;
    logic [18:0] b_addr;

    logic [15:0] sx, sy, s_lines, s_clips;
    logic [3:0]  sc, s_cc, s_data;
    logic        sv, sl, s_ready, s_cs, s_we, s_mr, s_busy, s_done;
    logic [2:0]  s_addr;

    fb_pixel_writer dut_big (
        .clk(clk), .rst_n(rst_n), .pix_x(bx), .pix_y(by), .pix_colr(bc),
        .pix_valid(bv), .pix_last(bl), .pix_ready(b_ready), .clear_start(b_cs),
        .clear_colr(b_cc), .mem_addr(b_addr), .mem_data(b_data), .mem_we(b_we),
        .mem_ready(b_mr), .busy(b_busy), .clear_done(b_done),
        .line_count(b_lines), .clip_count(b_clips)
    );

    fb_pixel_writer #(.H_RES(4), .V_RES(2), .ADDR_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .pix_x(sx), .pix_y(sy), .pix_colr(sc),
        .pix_valid(sv), .pix_last(sl), .pix_ready(s_ready), .clear_start(s_cs),
        .clear_colr(s_cc), .mem_addr(s_addr), .mem_data(s_data), .mem_we(s_we),
        .mem_ready(s_mr), .busy(s_busy), .clear_done(s_done),
        .line_count(s_lines), .clip_count(s_clips)
    );

    typedef struct { int addr; int data; } wr_t;
    wr_t obs_b[$], obs_s[$], exp_b[$], exp_s[$];
    int  checks = 0, errors = 0;
    int  lines_m = 0, clips_m = 0;
    bit  rand_mr = 0;

    // A write is taken on the edge following a negedge where we && ready are high.
    always @(negedge clk) begin
        if (b_we && b_mr) obs_b.push_back('{int'(b_addr), int'(b_data)});
        if (s_we && s_mr) obs_s.push_back('{int'(s_addr), int'(s_data)});
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mr) begin
            b_mr = 1'($urandom_range(0, 1));
            s_mr = 1'($urandom_range(0, 1));
        end
    endtask

    // Offers one beat until accepted; updates the reference model on acceptance.
    task automatic send(input bit sel, input int x, input int y, input int c, input bit last);
        bit acc = 0, r;
        int h = sel ? 4 : 640;
        int v = sel ? 2 : 480;
        if (!sel) begin bx = 16'(x); by = 16'(y); bc = 4'(c); bl = last; bv = 1; end
        else      begin sx = 16'(x); sy = 16'(y); sc = 4'(c); sl = last; sv = 1; end
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge clk);
            r = sel ? s_ready : b_ready;
            tick();
            if (r) acc = 1;
        end
        bv = 0; sv = 0; bl = 0; sl = 0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL beat_accept: (%0d,%0d) accepted=%0d required=1", x, y, acc);
        end else if (x >= h || y >= v) begin
            if (!sel) clips_m++;
        end else begin
            if (!sel) exp_b.push_back('{y * h + x, c});
            else      exp_s.push_back('{y * h + x, c});
        end
        if (acc && last && !sel) lines_m++;
    endtask

    task automatic wait_idle_b();
        int n = 0;
        while (b_busy && n < 1000) begin tick(); n++; end
        checks++;
        if (b_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%0b required=0", b_busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; bv = 0; bl = 0; b_cs = 0; b_cc = 0; bx = 0; by = 0; bc = 0; b_mr = 1;
        sv = 0; sl = 0; s_cs = 0; s_cc = 0; sx = 0; sy = 0; sc = 0; s_mr = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({b_we, b_addr, b_data, b_busy, b_done, b_ready} !== '0) begin
            errors++;
            $display("FAIL reset_mem_outputs: got we=%0b addr=%0d data=%0d busy=%0b done=%0b ready=%0b required all 0",
                     b_we, b_addr, b_data, b_busy, b_done, b_ready);
        end
        checks++;
        if ({b_lines, b_clips} !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: lines=%0d clips=%0d required 0", b_lines, b_clips);
        end
        rst_n = 1;
        tick();
        checks++;
        if (b_ready !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: big=%0b small=%0b required 1", b_ready, s_ready);
        end
    endtask

    task automatic test_single();
        obs_b.delete(); exp_b.delete();
        b_mr = 1;
        send(0, 3, 2, 5, 1);
        checks++;
        if (b_we !== 1'b1 || b_addr !== 19'd1283 || b_data !== 4'd5) begin
            errors++;
            $display("FAIL single_latency: we=%0b addr=%0d data=%0d required we=1 addr=1283 data=5",
                     b_we, b_addr, b_data);
        end
        tick();
        checks++;
        if (b_we !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: we=%0b busy=%0b required 0 0", b_we, b_busy);
        end
        checks++;
        if (b_lines !== 16'(lines_m) || obs_b.size() != 1) begin
            errors++;
            $display("FAIL single_count: lines=%0d writes=%0d required %0d 1", b_lines, obs_b.size(), lines_m);
        end
    endtask

    task automatic test_backpressure();
        int  idx = 0, stall_bad = 0;
        bit  r;
        int  col[6];
        obs_b.delete(); exp_b.delete();
        for (int i = 0; i < 6; i++) col[i] = int'($urandom_range(0, 15));
        b_mr = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            bx = 16'(idx); by = 0; bc = 4'(col[idx]); bl = 0; bv = 1;
            @(negedge clk);
            r = b_ready;
            if (idx > 0 && (b_we !== 1'b1 || b_addr !== 19'd0 || b_data !== 4'(col[0]))) stall_bad++;
            tick();
            if (r) begin exp_b.push_back('{idx, col[idx]}); idx++; end
        end
        bv = 0;
        checks++;
        if (idx != 4 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: accepted=%0d ready=%0b required 4 0", idx, b_ready);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL bp_stable: unstable_cycles=%0d required 0", stall_bad);
        end
        b_mr = 1;
        send(0, 4, 0, col[4], 0);
        send(0, 5, 0, col[5], 0);
        wait_idle_b();
        checks++;
        if (obs_b.size() != exp_b.size()) begin
            errors++;
            $display("FAIL bp_count: writes=%0d required %0d", obs_b.size(), exp_b.size());
        end
        for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
            checks++;
            if (obs_b[i].addr != exp_b[i].addr || obs_b[i].data != exp_b[i].data) begin
                errors++;
                $display("FAIL bp_write[%0d]: addr=%0d data=%0d required addr=%0d data=%0d",
                         i, obs_b[i].addr, obs_b[i].data, exp_b[i].addr, exp_b[i].data);
            end
        end
    endtask

    task automatic test_clip();
        obs_b.delete(); exp_b.delete();
        b_mr = 1;
        send(0, 640, 0, int'($urandom_range(0, 15)), 1);
        send(0, 0, 480, int'($urandom_range(0, 15)), 0);
        send(0, 639, 479, 9, 0);
        wait_idle_b();
        checks++;
        if (b_clips !== 16'd2 || obs_b.size() != 1 || (obs_b.size() == 1 && obs_b[0].addr != 307199)) begin
            errors++;
            $display("FAIL clip_edges: clips=%0d writes=%0d required clips=2 one write at 307199",
                     b_clips, obs_b.size());
        end
        rand_mr = 1;
        for (int i = 0; i < 40; i++)
            send(0, int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                 int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        wait_idle_b();
        rand_mr = 0; b_mr = 1;
        checks++;
        if (b_clips !== 16'(clips_m) || b_lines !== 16'(lines_m)) begin
            errors++;
            $display("FAIL clip_counters: clips=%0d lines=%0d required %0d %0d", b_clips, b_lines, clips_m, lines_m);
        end
        checks++;
        if (obs_b.size() != exp_b.size()) begin
            errors++;
            $display("FAIL clip_count_writes: writes=%0d required %0d", obs_b.size(), exp_b.size());
        end
        for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
            checks++;
            if (obs_b[i].addr != exp_b[i].addr || obs_b[i].data != exp_b[i].data) begin
                errors++;
                $display("FAIL rand_write[%0d]: addr=%0d data=%0d required addr=%0d data=%0d",
                         i, obs_b[i].addr, obs_b[i].data, exp_b[i].addr, exp_b[i].data);
            end
        end
    endtask

    task automatic test_clear();
        int bad = 0, done_cnt = 0, after = 0;
        bit done_seen = 0;
        obs_s.delete(); exp_s.delete();
        s_mr = 0;
        send(1, 0, 1, 3, 0);
        send(1, 2, 0, 9, 0);
        s_cs = 1; s_cc = 7;
        tick();
        s_cs = 0;
        for (int a = 0; a < 8; a++) exp_s.push_back('{a, 7});
        for (int n = 0; n < 200 && after < 5; n++) begin
            if (n == 3) s_mr = 1;
            if (s_done) begin done_cnt++; done_seen = 1; end
            if (!done_seen && s_ready !== 1'b0) bad++;
            if (done_seen) after++;
            tick();
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL clear_done_pulses: got %0d required 1", done_cnt);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_ready_low: ready_high_cycles=%0d required 0", bad);
        end
        checks++;
        if (obs_s.size() != exp_s.size()) begin
            errors++;
            $display("FAIL clear_count: writes=%0d required %0d", obs_s.size(), exp_s.size());
        end
        for (int i = 0; i < obs_s.size() && i < exp_s.size(); i++) begin
            checks++;
            if (obs_s[i].addr != exp_s[i].addr || obs_s[i].data != exp_s[i].data) begin
                errors++;
                $display("FAIL clear_write[%0d]: addr=%0d data=%0d required addr=%0d data=%0d",
                         i, obs_s[i].addr, obs_s[i].data, exp_s[i].addr, exp_s[i].data);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int n = 0;
        s_mr = 1;
        s_cs = 1; s_cc = 4'($urandom_range(1, 15));
        tick();
        s_cs = 0;
        while (!(s_we && s_addr == 3'd3) && n < 100) begin tick(); n++; end
        checks++;
        if (!(s_we && s_addr == 3'd3)) begin
            errors++;
            $display("FAIL rmc_reach: we=%0b addr=%0d required we=1 addr=3", s_we, s_addr);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({s_we, s_addr, s_data, s_busy, s_done, s_ready, s_lines, s_clips} !== '0) begin
            errors++;
            $display("FAIL rmc_outputs: we=%0b addr=%0d data=%0d busy=%0b done=%0b ready=%0b required all 0",
                     s_we, s_addr, s_data, s_busy, s_done, s_ready);
        end
        lines_m = 0; clips_m = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        obs_s.delete();
        tick();
        checks++;
        if (s_ready !== 1'b1 || s_busy !== 1'b0 || b_lines !== 16'(lines_m)) begin
            errors++;
            $display("FAIL rmc_release: ready=%0b busy=%0b big_lines=%0d required 1 0 %0d",
                     s_ready, s_busy, b_lines, lines_m);
        end
        repeat (20) tick();
        checks++;
        if (obs_s.size() != 0) begin
            errors++;
            $display("FAIL rmc_no_replay: writes=%0d required 0", obs_s.size());
        end
    endtask

    task automatic test_back_to_back();
        bit r, sent2 = 0, done = 0;
        int pc = int'($urandom_range(0, 15));
        int cc = int'($urandom_range(0, 15));
        obs_s.delete(); exp_s.delete();
        s_mr = 1;
        sx = 1; sy = 1; sc = 4'(pc); sl = 1; sv = 1; s_cs = 1; s_cc = 4'(cc);
        @(negedge clk);
        r = s_ready;
        tick();
        sv = 0; sl = 0; s_cs = 0;
        checks++;
        if (r !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: ready=%0b required 1", r);
        end
        exp_s.push_back('{5, pc});
        for (int a = 0; a < 8; a++) exp_s.push_back('{a, cc});
        rand_mr = 1;
        for (int n = 0; n < 400 && !done; n++) begin
            if (s_cs) s_cs = 0;
            else if (!sent2 && obs_s.size() >= 3) begin s_cs = 1; s_cc = 4'(cc ^ 15); sent2 = 1; end
            tick();
            if (s_done) done = 1;
        end
        rand_mr = 0; s_cs = 0; s_mr = 1;
        repeat (30) tick();
        checks++;
        if (!done || s_busy !== 1'b0 || obs_s.size() != exp_s.size()) begin
            errors++;
            $display("FAIL b2b_count: done=%0b busy=%0b writes=%0d required 1 0 %0d",
                     done, s_busy, obs_s.size(), exp_s.size());
        end
        for (int i = 0; i < obs_s.size() && i < exp_s.size(); i++) begin
            checks++;
            if (obs_s[i].addr != exp_s[i].addr || obs_s[i].data != exp_s[i].data) begin
                errors++;
                $display("FAIL b2b_write[%0d]: addr=%0d data=%0d required addr=%0d data=%0d",
                         i, obs_s[i].addr, obs_s[i].data, exp_s[i].addr, exp_s[i].data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_clip();
        test_clear();
        test_reset_mid_clear();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
